debounce_array: RTL and testbench
=================================

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 SHALL have parameter STABLE_CYCLES, default 25000000: cycles a synchronised input must hold a new level before acceptance, legal range >= 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000: cycles in HELD before long_pulse, legal range >= 1.
REQ-004 SHALL have parameter INV_MASK [N_CH-1:0], default all 0: bit set means that channel's button is active-low and is inverted before synchronisation.
REQ-005 SHALL have port clk, input, 1: single clock; all flops on posedge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port button, input, N_CH: raw asynchronous button levels.
REQ-008 SHALL have port level, output, N_CH: debounced level per channel, 1 = pressed.
REQ-009 SHALL have port press_pulse, output, N_CH: one-cycle strobe per accepted press.
REQ-010 SHALL have port release_pulse, output, N_CH: one-cycle strobe per accepted release.
REQ-011 SHALL have port long_pulse, output, N_CH: one-cycle strobe once per press held LONG_CYCLES.

Function
REQ-012 SHALL pass each channel through two flops after XOR with INV_MASK bit; FSM sees only the second flop (s).
REQ-013 SHALL run per channel a 4-state FSM: RELEASED, PRESS_CHK, HELD, RELEASE_CHK, plus a stability counter (clog2(STABLE_CYCLES) bits) and a long counter (clog2(LONG_CYCLES+1) bits).
REQ-014 RELEASED: s=1 -> PRESS_CHK, stability counter cleared to 0; else stay.
REQ-015 PRESS_CHK: s=0 -> RELEASED (bounce rejected, no pulse); else counter increments; at counter == STABLE_CYCLES-1 with s=1 -> HELD, long counter cleared.
REQ-016 HELD: s=0 -> RELEASE_CHK, stability counter cleared; long counter increments, saturating at LONG_CYCLES.
REQ-017 RELEASE_CHK: s=1 -> HELD, long counter NOT cleared; else counter increments; at counter == STABLE_CYCLES-1 with s=0 -> RELEASED.
REQ-018 Long counter SHALL keep counting in RELEASE_CHK (the press is still logically held).
REQ-019 level SHALL be 1 exactly when state is HELD or RELEASE_CHK; registered, no combinational path from button.
REQ-020 press_pulse SHALL be high only in the first cycle of HELD entered from PRESS_CHK; re-entry from RELEASE_CHK gives no pulse.
REQ-021 release_pulse SHALL be high only in the first cycle of RELEASED entered from RELEASE_CHK.
REQ-022 long_pulse SHALL be high in the single cycle after the long counter reaches LONG_CYCLES; at most once per accepted press.
REQ-023 Latency: raw rise before edge 1, held clean -> press_pulse high in the cycle after edge STABLE_CYCLES+3; release symmetric.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.

Reset
REQ-025 While rst_n=0: sync flops 0, state RELEASED, both counters 0, all outputs 0; takes effect immediately, asynchronously.
REQ-026 Reset mid-press SHALL abort without release_pulse; a button still held at deassertion is re-qualified from RELEASED as a new press.

Structure
REQ-027 Package debounce_pkg SHALL hold the state enum typedef (2-bit) and default parameter constants.
REQ-028 Per-channel logic SHALL be sub-module debounce_ch, instantiated N_CH times by generate; debounce_array holds only parameter checks and wiring.

Verification (STABLE_CYCLES=4, LONG_CYCLES=10, N_CH=4, INV_MASK=4'b1000)
REQ-029 Clean press on ch0 held 30 cycles -> press_pulse[0] one cycle after edge 7; level[0]=1 from then; long_pulse[0] once, 11 cycles after press_pulse.
REQ-030 Bounce ch1: high 2, low 1, high 2, low -> no pulses, level[1] stays 0.
REQ-031 Held ch0 glitches low 2 cycles -> level stays 1, no release_pulse, no second press_pulse; clean release -> release_pulse one cycle after edge 7 from release.
REQ-032 ch3 driven 1 after reset, then 0 -> no press while 1; press_pulse[3] 7 edges after driving 0.
REQ-033 rst_n asserted while ch2 HELD -> outputs 0 at once, no release_pulse; deassert with button high -> fresh press_pulse 7 edges later.
REQ-034 ch0 and ch1 rise same cycle -> press_pulse[0] and [1] high in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared state encoding and default parameters for debounce_array.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    localparam int c_def_n_ch          = 4;
    localparam int c_def_stable_cycles = 25000000;
    localparam int c_def_long_cycles   = 50000000;

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : debounce_ch
// Brief    : One button channel: 2-flop sync, 4-state debounce FSM, pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = c_def_stable_cycles,
    parameter int   LONG_CYCLES   = c_def_long_cycles,
    parameter logic INV           = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int c_STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int c_LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [c_LONG_W-1:0] c_LONG_MAX  = c_LONG_W'(LONG_CYCLES);

    logic                r_sync1;
    logic                r_sync;
    state_t              r_state;
    logic [c_STAB_W-1:0] r_stab;
    logic [c_LONG_W-1:0] r_long;
    logic                r_long_fired;
    logic                r_press;
    logic                r_release;
    logic                r_long_pulse;
    logic                w_held;

    // The press stays logically held through the release check window.
    assign w_held = (r_state == ST_HELD) || (r_state == ST_RELEASE_CHK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync       <= 1'b0;
            r_state      <= ST_RELEASED;
            r_stab       <= '0;
            r_long       <= '0;
            r_long_fired <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_pulse <= 1'b0;
        end else begin
            r_sync1      <= i_button ^ INV;
            r_sync       <= r_sync1;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_pulse <= 1'b0;

            if (w_held && (r_long == c_LONG_MAX) && !r_long_fired) begin
                r_long_pulse <= 1'b1;
                r_long_fired <= 1'b1;
            end
            if (w_held && (r_long != c_LONG_MAX)) begin
                r_long <= r_long + 1'b1;
            end

            case (r_state)
                ST_RELEASED: begin
                    if (r_sync) begin
                        r_state <= ST_PRESS_CHK;
                        r_stab  <= '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!r_sync) begin
                        r_state <= ST_RELEASED;
                    end else if (r_stab == c_STAB_LAST) begin
                        r_state      <= ST_HELD;
                        r_long       <= '0;
                        r_long_fired <= 1'b0;
                        r_press      <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!r_sync) begin
                        r_state <= ST_RELEASE_CHK;
                        r_stab  <= '0;
                    end
                end
                ST_RELEASE_CHK: begin
                    if (r_sync) begin
                        r_state <= ST_HELD;
                    end else if (r_stab == c_STAB_LAST) begin
                        r_state   <= ST_RELEASED;
                        r_release <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
                default: r_state <= ST_RELEASED;
            endcase
        end
    end

    assign o_level         = w_held;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_long_pulse    = r_long_pulse;

endmodule
`default_nettype wire

// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : debounce_array
// Brief    : N_CH independent debounced buttons with press/release/long pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_array
    import debounce_pkg::*;
#(
    parameter int              N_CH          = c_def_n_ch,
    parameter int              STABLE_CYCLES = c_def_stable_cycles,
    parameter int              LONG_CYCLES   = c_def_long_cycles,
    parameter logic [N_CH-1:0] INV_MASK      = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    generate
        if ((N_CH < 1) || (N_CH > 32)) begin : g_chk_n_ch
            $error("debounce_array: N_CH must be 1..32");
        end
        if (STABLE_CYCLES < 2) begin : g_chk_stable
            $error("debounce_array: STABLE_CYCLES must be >= 2");
        end
        if (LONG_CYCLES < 1) begin : g_chk_long
            $error("debounce_array: LONG_CYCLES must be >= 1");
        end
    endgenerate

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_ch #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .LONG_CYCLES   (LONG_CYCLES),
                .INV           (INV_MASK[i])
            ) u_ch (
                .clk             (clk),
                .rst_n           (rst_n),
                .i_button        (button[i]),
                .o_level         (level[i]),
                .o_press_pulse   (press_pulse[i]),
                .o_release_pulse (release_pulse[i]),
                .o_long_pulse    (long_pulse[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_array
// Brief    : Directed and random stimulus against a run-length debounce model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_array;

    localparam int         c_N      = 4;
    localparam int         c_STABLE = 4;
    localparam int         c_LONG   = 10;
    localparam logic [3:0] c_INV    = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;

    int errors = 0;
    int checks = 0;

    debounce_array #(
        .N_CH          (c_N),
        .STABLE_CYCLES (c_STABLE),
        .LONG_CYCLES   (c_LONG),
        .INV_MASK      (c_INV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once the synchronised input has disagreed
    // with the accepted level for STABLE+1 consecutive samples.
    logic [3:0] m_s1, m_s, m_L, e_press, e_rel, e_long;
    int         m_run [4];
    longint     m_acc [4];
    bit         m_acc_v [4];
    longint     m_cyc;

    task automatic model_reset();
        m_s1 = '0; m_s = '0; m_L = '0;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int ch = 0; ch < c_N; ch++) begin
            m_run[ch] = 0; m_acc[ch] = 0; m_acc_v[ch] = 1'b0;
        end
    endtask

    task automatic model_step();
        m_cyc++;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int ch = 0; ch < c_N; ch++) begin
            if (m_L[ch] && m_acc_v[ch] && (m_cyc == m_acc[ch] + c_LONG + 1))
                e_long[ch] = 1'b1;
            if (m_s[ch] != m_L[ch]) m_run[ch]++;
            else                    m_run[ch] = 0;
            if (m_run[ch] == c_STABLE + 1) begin
                m_L[ch]   = ~m_L[ch];
                m_run[ch] = 0;
                if (m_L[ch]) begin
                    e_press[ch] = 1'b1;
                    m_acc[ch]   = m_cyc;
                    m_acc_v[ch] = 1'b1;
                end else begin
                    e_rel[ch] = 1'b1;
                end
            end
        end
        m_s  = m_s1;
        m_s1 = button ^ c_INV;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_level",   level,         m_L);
            check("cmp_press",   press_pulse,   e_press);
            check("cmp_release", release_pulse, e_rel);
            check("cmp_long",    long_pulse,    e_long);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rate;

    initial begin
        button = 4'b1000;
        repeat (3) @(negedge clk);
        check("rst_level",   level,         4'b0000);
        check("rst_press",   press_pulse,   4'b0000);
        check("rst_release", release_pulse, 4'b0000);
        check("rst_long",    long_pulse,    4'b0000);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press on ch0, long pulse, glitch, clean release
        @(negedge clk); button[0] = 1'b1;
        edges(6);  check("t1_press_e6", press_pulse, 4'b0000);
        edges(1);  check("t1_press_e7", press_pulse, 4'b0001);
                   check("t1_level_e7", level,       4'b0001);
        edges(10); check("t1_long_e17", long_pulse,  4'b0000);
        edges(1);  check("t1_long_e18", long_pulse,  4'b0001);
        edges(1);  check("t1_long_e19", long_pulse,  4'b0000);
        @(negedge clk); button[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); button[0] = 1'b1;
        edges(8);  check("t1_glitch_level", level, 4'b0001);
        @(negedge clk); button[0] = 1'b0;
        edges(6);  check("t1_rel_e6", release_pulse, 4'b0000);
        edges(1);  check("t1_rel_e7", release_pulse, 4'b0001);
                   check("t1_rel_level", level,      4'b0000);

        // Bounce on ch1
        @(negedge clk); button[1] = 1'b1;
        @(negedge clk);
        @(negedge clk); button[1] = 1'b0;
        @(negedge clk); button[1] = 1'b1;
        @(negedge clk);
        @(negedge clk); button[1] = 1'b0;
        edges(12); check("t2_bounce_level", level, 4'b0000);

        // Active-low ch3
        @(negedge clk); button[3] = 1'b0;
        edges(6);  check("t3_press_e6", press_pulse, 4'b0000);
        edges(1);  check("t3_press_e7", press_pulse, 4'b1000);
        @(negedge clk); button[3] = 1'b1;
        edges(10);

        // Reset while ch2 held, re-qualified afterwards
        @(negedge clk); button[2] = 1'b1;
        edges(10); check("t4_level", level, 4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_level",   level,         4'b0000);
        check("t4_rst_release", release_pulse, 4'b0000);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        edges(6);  check("t4_press_e6", press_pulse, 4'b0000);
        edges(1);  check("t4_press_e7", press_pulse, 4'b0100);
        @(negedge clk); button[2] = 1'b0;
        edges(10);

        // Simultaneous press on ch0 and ch1
        @(negedge clk); button[1:0] = 2'b11;
        edges(7);  check("t5_press_both", press_pulse, 4'b0011);
        @(negedge clk); button[1:0] = 2'b00;
        edges(10); check("t5_level_idle", level, 4'b0000);

        // Random: varying toggle density, occasional reset
        rate = 8;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 200 == 0) rate = $urandom_range(0, 2) == 0 ? 2 :
                                       ($urandom_range(0, 1) == 0 ? 8 : 40);
            for (int ch = 0; ch < c_N; ch++) begin
                if ($urandom_range(0, rate - 1) == 0) button[ch] = ~button[ch];
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
